tdc_multihit_capture: RTL

Parametrised multi-channel, multi-hit TDC timestamp collector running on the PLL clock. On each TDC start it opens a measurement window and runs a coarse counter. For every trigger rising edge it captures {coarse count, DLL fine code} into a per-channel hit buffer. At window end it raises the done interrupt and serves timestamps through a shared read port for the SPI/register layer. It generalises the current single-shot two-trigger path to N channels, several hits per channel, and a configurable window.

---
 rtl/tdc_multihit_capture.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/tdc_multihit_capture.sv
// Multi-channel, multi-hit TDC timestamp collector: a windowed coarse counter plus the
// DLL fine code are captured per trigger edge into per-channel FIFOs and read back one at a time.
module tdc_multihit_capture #(
  parameter  int N_CH     = 2,
  parameter  int PHASES   = 16,
  parameter  int CW       = 12,
  parameter  int MAX_HITS = 4,
  localparam int FW       = $clog2(PHASES),
  localparam int HW       = $clog2(MAX_HITS + 1),
  localparam int CHW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk_pll,
  input  logic                   rst,
  input  logic                   cfg_en,
  input  logic [CW-1:0]          cfg_window,
  input  logic                   tdc_start,
  input  logic [N_CH-1:0]        trig,
  input  logic [N_CH*PHASES-1:0] phase,
  input  logic                   rd_en,
  input  logic [CHW-1:0]         rd_ch,
  output logic                   rd_valid,
  output logic [CW+FW-1:0]       rd_data,
  output logic                   rd_empty,
  output logic [N_CH*HW-1:0]     hit_cnt,
  output logic [N_CH-1:0]        ovf,
  output logic                   busy,
  output logic                   irq_hit,
  output logic                   irq_done
);

  localparam int          AW   = (MAX_HITS > 1) ? $clog2(MAX_HITS) : 1;
  localparam int          TW   = CW + FW;
  localparam logic [HW-1:0] FULL = HW'(MAX_HITS);
  localparam int unsigned FMAX = PHASES - 1;

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  state_t          state, state_nxt;
  logic            start_go;
  logic [CW-1:0]   coarse, win_last;
  logic [N_CH-1:0] trig_d, edges, store;
  logic [FW-1:0]   fine [N_CH];
  logic [TW-1:0]   mem  [N_CH][MAX_HITS];
  logic [HW-1:0]   cnt  [N_CH];
  logic [HW-1:0]   rptr [N_CH];
  logic            hit_seen;
  logic            rd_in_range, rd_hit, rd_serve;

  always_ff @(posedge clk_pll or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    win_last  = (cfg_window == '0) ? '0 : cfg_window - 1'b1;
    case (state)
      IDLE: begin
        if (tdc_start && cfg_en) begin
          state_nxt = ARMED;
          start_go  = 1'b1;
        end
      end
      ARMED: begin
        if (!cfg_en)                 state_nxt = IDLE;
        else if (coarse == win_last) state_nxt = DONE;
      end
      DONE: begin
        if (!cfg_en) state_nxt = IDLE;
        else if (tdc_start) begin
          state_nxt = ARMED;
          start_go  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state == ARMED);
  assign irq_done = (state == DONE);

  // Fine code is the thermometer popcount, clipped so a fully-set snapshot maps to PHASES-1.
  always_comb begin
    int unsigned ones;
    for (int unsigned c = 0; c < N_CH; c++) begin
      ones = 0;
      for (int unsigned i = 0; i < PHASES; i++)
        if (phase[c*PHASES + i]) ones++;
      fine[c] = (ones > FMAX) ? FW'(FMAX) : FW'(ones);
    end
  end

  always_comb begin
    edges   = trig & ~trig_d;
    store   = '0;
    hit_cnt = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      store[c]              = (state == ARMED) && edges[c] && (cnt[c] < FULL);
      hit_cnt[c*HW +: HW]   = cnt[c];
    end
    rd_in_range = ({1'b0, rd_ch} < (CHW+1)'(N_CH));
    rd_hit      = rd_in_range && (cnt[rd_ch] != '0);
    rd_serve    = rd_en && (state != ARMED);
  end

  // Writes only occur in a window that began with empty buffers and reads never happen
  // while armed, so the write slot is simply the current count.
  always_ff @(posedge clk_pll or posedge rst) begin
    if (rst) begin
      trig_d   <= '0;
      coarse   <= '0;
      hit_seen <= 1'b0;
      irq_hit  <= 1'b0;
      ovf      <= '0;
      rd_valid <= 1'b0;
      rd_empty <= 1'b0;
      rd_data  <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        cnt[c]  <= '0;
        rptr[c] <= '0;
        for (int unsigned h = 0; h < MAX_HITS; h++) mem[c][h] <= '0;
      end
    end else begin
      trig_d   <= trig;
      irq_hit  <= 1'b0;
      rd_valid <= 1'b0;
      rd_empty <= 1'b0;
      if (start_go) begin
        coarse   <= '0;
        hit_seen <= 1'b0;
        ovf      <= '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
          cnt[c]  <= '0;
          rptr[c] <= '0;
        end
      end else if (state == ARMED) begin
        coarse <= coarse + 1'b1;
        if ((|store) && !hit_seen) begin
          irq_hit  <= 1'b1;
          hit_seen <= 1'b1;
        end
        for (int unsigned c = 0; c < N_CH; c++) begin
          if (store[c]) begin
            mem[c][AW'(cnt[c])] <= {coarse, fine[c]};
            cnt[c]              <= cnt[c] + 1'b1;
          end else if (edges[c]) begin
            ovf[c] <= 1'b1;
          end
        end
      end
      if (rd_serve) begin
        rd_valid <= 1'b1;
        if (rd_hit) begin
          rd_data <= mem[rd_ch][AW'(rptr[rd_ch])];
          if (!start_go) begin
            cnt[rd_ch]  <= cnt[rd_ch] - 1'b1;
            rptr[rd_ch] <= rptr[rd_ch] + 1'b1;
          end
        end else begin
          rd_data  <= '0;
          rd_empty <= 1'b1;
        end
      end
    end
  end

endmodule
